// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - funct3 encodings, LSU state encoding and access legality helper
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // True when funct3 is a valid encoding for the access kind and the address suits its size
    function automatic logic access_ok(input logic [2:0] f3, input logic is_store,
                                       input logic [1:0] a);
        logic ok;
        case (f3)
            F3_LB:   ok = 1'b1;
            F3_LH:   ok = !a[0];
            F3_LW:   ok = (a == 2'b00);
            F3_LBU:  ok = !is_store;
            F3_LHU:  ok = !is_store && !a[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - load lane selection and sign/zero extension
module load_extract
    import riscv_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
    assign lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];

    // Pick the addressed lane and widen it according to the load kind
    always_comb begin
        data = '0;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){lane_b[7]}}, lane_b};
            F3_LH:   data = {{(XLEN-16){lane_h[15]}}, lane_h};
            F3_LW:   data = rdata;
            F3_LBU:  data = {{(XLEN-8){1'b0}}, lane_b};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, lane_h};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM stage load/store unit with data-bus handshake and MEM/WB register
module mem_stage_lsu
    import riscv_mem_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] me_alu_o,
    input  logic [XLEN-1:0] me_regs_data2,
    input  logic [RD_W-1:0] me_rd,
    input  logic [2:0]      me_funct3,
    input  logic            me_mem_read,
    input  logic            me_mem_write,
    input  logic            me_mem2reg,
    input  logic            me_regs_write,
    output logic            dbus_req,
    output logic            dbus_we,
    output logic [XLEN-1:0] dbus_addr,
    output logic [XLEN-1:0] dbus_wdata,
    output logic [3:0]      dbus_be,
    input  logic            dbus_gnt,
    input  logic            dbus_rvalid,
    input  logic [XLEN-1:0] dbus_rdata,
    output logic            mem_stall,
    output logic [XLEN-1:0] wb_data,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_regs_write,
    output logic            misalign_err
);

    lsu_state_e      state;
    lsu_state_e      next_state;
    logic            acc_any;
    logic            acc_legal;
    logic            acc_bad;
    logic            we_q;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] load_q;
    logic [3:0]      be_calc;
    logic [XLEN-1:0] wdata_calc;

    assign acc_any   = me_mem_read | me_mem_write;
    assign acc_legal = (me_mem_read ^ me_mem_write) &&
                       access_ok(me_funct3, me_mem_write, me_alu_o[1:0]);
    assign acc_bad   = acc_any && !acc_legal;

    load_extract #(.XLEN(XLEN)) u_load_extract (
        .rdata   (dbus_rdata),
        .addr_lo (me_alu_o[1:0]),
        .funct3  (me_funct3),
        .data    (load_ext)
    );

    // Byte enables and lane-replicated write data for the pending access
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = me_regs_data2;
        case (me_funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << me_alu_o[1:0];
                wdata_calc = {(XLEN/8){me_regs_data2[7:0]}};
            end
            2'b01: begin
                be_calc    = me_alu_o[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {(XLEN/16){me_regs_data2[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = me_regs_data2;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, bus strobes and stall
    always_comb begin
        next_state = state;
        mem_stall  = 1'b0;
        dbus_req   = 1'b0;
        dbus_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (acc_legal) begin
                    mem_stall  = 1'b1;
                    next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_stall = 1'b1;
                dbus_req  = 1'b1;
                dbus_we   = we_q;
                if (dbus_gnt) begin
                    next_state = we_q ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                mem_stall = 1'b1;
                if (dbus_rvalid) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        if (rst) begin
            mem_stall = 1'b0;
        end
    end

    // Bus request fields, load data latch, error pulse and MEM/WB register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbus_addr     <= '0;
            dbus_wdata    <= '0;
            dbus_be       <= '0;
            we_q          <= 1'b0;
            load_q        <= '0;
            misalign_err  <= 1'b0;
            wb_data       <= '0;
            wb_rd         <= '0;
            wb_regs_write <= 1'b0;
        end else begin
            misalign_err <= (state == ST_IDLE) && acc_bad;
            if ((state == ST_IDLE) && acc_legal) begin
                dbus_addr  <= {me_alu_o[XLEN-1:2], 2'b00};
                dbus_wdata <= wdata_calc;
                dbus_be    <= be_calc;
                we_q       <= me_mem_write;
            end
            if ((state == ST_WAIT) && dbus_rvalid) begin
                load_q <= load_ext;
            end
            if (mem_stall || ((state == ST_IDLE) && acc_bad)) begin
                wb_regs_write <= 1'b0;
            end else begin
                wb_data       <= ((state == ST_DONE) && me_mem2reg) ? load_q : me_alu_o;
                wb_rd         <= me_rd;
                wb_regs_write <= me_regs_write;
            end
        end
    end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- XLEN, 32, data and address width.
- RD_W, 5, register index width.

REQ-002 Ports SHALL be (name, direction, width, meaning); clock and reset first:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- me_alu_o  in  XLEN  effective address, or ALU result for non-memory instructions.
- me_regs_data2  in  XLEN  store data.
- me_rd  in  RD_W  destination register.
- me_funct3  in  3  access size and signedness.
- me_mem_read  in  1  load.
- me_mem_write  in  1  store.
- me_mem2reg  in  1  writeback selects load data.
- me_regs_write  in  1  register write enable.
- dbus_req / dbus_we  out  1  request / write strobe.
- dbus_addr  out  XLEN  word-aligned address.
- dbus_wdata  out  XLEN  write data.
- dbus_be  out  4  byte enables.
- dbus_gnt  in  1  request accepted.
- dbus_rvalid  in  1  read data valid.
- dbus_rdata  in  XLEN  read data.
- mem_stall  out  1  holds the EX/MEM register and all earlier stages.
- wb_data  out  XLEN  MEM/WB result.
- wb_rd  out  RD_W  MEM/WB destination.
- wb_regs_write  out  1  MEM/WB write enable.
- misalign_err  out  1  one-cycle exception pulse.

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT, DONE.

REQ-004 IDLE, legal access pending (exactly one of me_mem_read/me_mem_write set):
- mem_stall=1, combinational.
- Next state REQ.

REQ-005 IDLE, no access:
- mem_stall=0.
- MEM/WB captures me_alu_o, me_rd and me_regs_write at the next edge (1-cycle latency).

REQ-006 REQ:
- dbus_req=1; dbus_addr, dbus_we, dbus_wdata and dbus_be held stable until dbus_gnt.
- On gnt, a store goes to DONE and a load goes to WAIT.

REQ-007 WAIT:
- dbus_req=0.
- On dbus_rvalid, the extracted load data is latched and the next state is DONE.

REQ-008 DONE:
- mem_stall=0.
- MEM/WB captures wb_data = me_mem2reg ? load data : me_alu_o.
- Next state IDLE.

REQ-009 mem_stall SHALL be 1 in REQ and WAIT.

REQ-010 Whenever mem_stall=1 at an edge, MEM/WB SHALL capture a bubble (wb_regs_write=0).

REQ-011 Store lanes (dbus_addr = {me_alu_o[XLEN-1:2],2'b00}):
- sb: be = 1<<addr[1:0], byte replicated x4.
- sh: be = 4'b0011 or 4'b1100 by addr[1], halfword replicated x2.
- sw: be = 4'b1111.

REQ-012 Loads: funct3 000/001/010/100/101 = lb/lh/lw/lbu/lhu, selecting the lane by addr[1:0]; signed forms sign-extend, unsigned forms zero-extend.

REQ-013 Misaligned access SHALL raise misalign_err for one cycle in IDLE, issue no bus request, assert no stall, and capture a bubble:
- halfword with addr[0]=1;
- word with addr[1:0]≠0;
- illegal funct3 (011/110/111);
- me_mem_read and me_mem_write both set.

REQ-014 dbus_gnt outside REQ and dbus_rvalid outside WAIT SHALL be ignored.

REQ-015 Minimum latency with gnt in REQ and rvalid on the first WAIT cycle: store 3 cycles stalled-through-DONE, load 4 cycles.

Reset
REQ-016 On rst assertion, without waiting for clk:
- state = IDLE;
- dbus_req, dbus_we, mem_stall, misalign_err, wb_regs_write = 0;
- wb_data, wb_rd, dbus_addr, dbus_wdata, dbus_be = 0.

REQ-017 Reset mid-transaction SHALL abandon the access; a late dbus_rvalid after release SHALL be ignored.

Structure
REQ-018 A shared package riscv_mem_pkg SHALL hold the funct3 load/store constants and the FSM state encoding.

REQ-019 Lane selection and sign extension SHALL live in a combinational sub-module load_extract, which is instantiated once.

Verification
REQ-020 Non-memory instruction, me_alu_o=0x1234, rd=5, regs_write=1 -> next edge wb_data=0x1234, wb_rd=5, mem_stall never 1.

REQ-021 sb addr=0x1003, data2=0x000000AB, gnt on first REQ cycle -> dbus_be=4'b1000, wdata=0xABABABAB, addr=0x1000, stall exactly 2 cycles, store completes.

REQ-022 lb addr=0x2001, rdata=0x0000_80FF -> wb_data=0xFFFFFF80; same with lbu -> 0x00000080.

REQ-023 lw addr=0x3002 -> misalign_err pulse 1 cycle, dbus_req never 1, wb_regs_write=0.

REQ-024 lw with gnt delayed 3 cycles and rvalid 2 cycles later -> addr/be stable throughout REQ, mem_stall continuous, wb_data=rdata in DONE.

REQ-025 rst asserted in WAIT, then rvalid pulse after release -> outputs zero immediately, state IDLE, rvalid ignored, wb_regs_write=0.
